// File: rtl/seg7_pkg.sv
// seg7_pkg: hex font table and segment constants shared by the seven-segment display blocks.
package seg7_pkg;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;
  localparam logic [6:0] SEG7_BLANK = 7'h00;
  // Index n holds the {a,b,c,d,e,f,g} pattern for hex digit n.
  localparam logic [6:0] SEG7_FONT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to {a..g} segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG7_FONT[nibble_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex display scanner with frame-aligned commit of new values.
// Define SEG7_SCAN_LZB_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done,
  output logic                  load_ack
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic                pending_q, pending_d, en_q;
  logic [6:0]          seg_q, seg_d, font_seg;
  logic [DIGITS-1:0]   sel_q, sel_d, nz;
  logic                fd_q, ack_q;
  logic                pwrap, ilast, boundary, commit_load, commit_shadow, blank;
  logic [3:0]          nib;
  assign pwrap    = pcnt_q == PW'(PRESCALE - 1);
  assign ilast    = idx_q == IW'(DIGITS - 1);
  assign boundary = enable & pwrap & ilast;
  assign commit_load   = load & (~enable | boundary);
  assign commit_shadow = boundary & pending_q & ~load;
  // The first enabled cycle holds pcnt at 0 so digit 0 gets a full dwell on the driven outputs.
  always_comb begin
    pcnt_d    = (!enable || !en_q || pwrap) ? '0 : pcnt_q + 1'b1;
    idx_d     = !enable ? '0 : pwrap ? (ilast ? '0 : idx_q + 1'b1) : idx_q;
    active_d  = commit_load ? data : commit_shadow ? shadow_q : active_q;
    shadow_d  = load ? data : shadow_q;
    pending_d = (commit_load || commit_shadow) ? 1'b0 : load ? 1'b1 : pending_q;
    nib       = active_d[{idx_d, 2'b00} +: 4];
    sel_d     = enable ? DIGITS'(1) << idx_d : '0;
    for (int i = 0; i < DIGITS; i++) nz[i] = |active_d[4*i +: 4];
`ifdef SEG7_SCAN_LZB_EN
    blank     = (idx_d != '0) && ((nz >> idx_d) == '0);
`else
    blank     = 1'b0;
`endif
    seg_d     = (!enable || blank) ? SEG7_BLANK : font_seg;
  end
  hex_to_seg7 u_dec (
    .nibble_i (nib),
    .seg_o    (font_seg)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q    <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      en_q      <= 1'b0;
      seg_q     <= SEG7_BLANK;
      sel_q     <= '0;
      fd_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      en_q      <= enable;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      fd_q      <= boundary;
      ack_q     <= commit_load | commit_shadow;
    end
  end
  assign seg        = seg_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;
  assign load_ack   = ack_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scoreboard bench for seg7_scan_driver with DIGITS=4, PRESCALE=4.
module tb_seg7_scan_driver;
  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] sel;
    logic       fd;
    logic       ack;
  } exp_t;
`ifdef SEG7_SCAN_LZB_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h7E;
`endif
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, load = 1'b0;
  logic [15:0] data = '0;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        frame_done, load_ack;
  exp_t        q[$];
  exp_t        e;
  int          n_chk = 0, n_fail = 0, mcnt = 0;
  always #5 clk = ~clk;
  seg7_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .data       (data),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .load_ack   (load_ack)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Stimulus for one clock edge plus the outputs expected right after that edge.
  task automatic step(input logic en, input logic ld, input logic [15:0] d,
                      input logic [6:0] s, input logic [3:0] sel, input logic fd, input logic ack);
    @(negedge clk);
    enable = en;
    load   = ld;
    data   = d;
    q.push_back({s, sel, fd, ack});
  endtask
  task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                       input logic fd0, input logic ack0,
                       input int la, input logic [15:0] da, input int lb, input logic [15:0] db);
    logic [6:0] sv [4];
    sv = '{s0, s1, s2, s3};
    for (int k = 0; k < 16; k++)
      step(1'b1, (k == la) || (k == lb), (k == la) ? da : db, sv[k/4], 4'(1 << (k/4)),
           (k == 0) ? fd0 : 1'b0, (k == 0) ? ack0 : 1'b0);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        mcnt++;
        chk($sformatf("seg@%0d", mcnt), 32'(seg), 32'(e.seg));
        chk($sformatf("digit_sel@%0d", mcnt), 32'(digit_sel), 32'(e.sel));
        chk($sformatf("frame_done@%0d", mcnt), 32'(frame_done), 32'(e.fd));
        chk($sformatf("load_ack@%0d", mcnt), 32'(load_ack), 32'(e.ack));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    chk("reset_seg", 32'(seg), 0);
    chk("reset_sel", 32'(digit_sel), 0);
    chk("reset_fd", 32'(frame_done), 0);
    chk("reset_ack", 32'(load_ack), 0);
    @(negedge clk);
    rst = 1'b0;
    frame(7'h7E, 7'h7E, 7'h7E, 7'h7E, 1'b0, 1'b0, 0, 16'h12AF, -1, 16'h0);
    frame(7'h47, 7'h77, 7'h6D, 7'h30, 1'b1, 1'b1, 2, 16'h1111, 7, 16'h2222);
    frame(7'h6D, 7'h6D, 7'h6D, 7'h6D, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
    frame(7'h79, 7'h79, 7'h79, 7'h79, 1'b1, 1'b1, 0, 16'h3333, -1, 16'h0);
    for (int k = 0; k < 10; k++)
      step(1'b1, 1'b0, 16'h0, 7'h79, 4'(1 << (k/4)), k == 0, 1'b0);
    for (int k = 0; k < 5; k++)
      step(1'b0, k == 2, 16'h4567, 7'h00, 4'h0, 1'b0, k == 2);
    frame(7'h70, 7'h5F, 7'h5B, 7'h33, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
    step(1'b1, 1'b0, 16'h0, 7'h70, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h9999, 7'h70, 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    #1;
    chk("midscan_reset_seg", 32'(seg), 0);
    chk("midscan_reset_sel", 32'(digit_sel), 0);
    chk("midscan_reset_fd", 32'(frame_done), 0);
    chk("midscan_reset_ack", 32'(load_ack), 0);
    @(negedge clk);
    rst = 1'b0;
    frame(7'h7E, 7'h7E, 7'h7E, 7'h7E, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
    step(1'b1, 1'b0, 16'h0, 7'h7E, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h0050, 7'h00, 4'h0, 1'b0, 1'b1);
    frame(7'h7E, 7'h5B, LZ, LZ, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
    step(1'b0, 1'b1, 16'h0000, 7'h00, 4'h0, 1'b0, 1'b1);
    frame(7'h7E, LZ, LZ, LZ, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
    @(negedge clk);
    enable = 1'b0;
    load   = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed multi-digit hex display driver: latches a packed word of DIGITS nibbles, scans one digit at a time at a programmable dwell rate, and drives shared segment lines a..g plus a one-hot digit select. It is the multi-digit successor of the single-digit hex-to-segment display stage. It sits between the datapath result registers and the board's common-segment LED array. New values are committed only at frame boundaries, so a scan never shows a mix of old and new digits.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8
- PRESCALE, 1024, clk cycles each digit is held; must be ≥2
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = scan and drive; 0 = blank outputs, hold scan position at digit 0
- load  in  1  1-cycle strobe; captures data into the shadow register
- data  in  4*DIGITS  packed nibbles; data[3:0] = digit 0 (rightmost, least significant)
- seg  out  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-high
- digit_sel  out  DIGITS  one-hot active-high digit enable; digit_sel[0] = digit 0
- frame_done  out  1  1-cycle pulse after the last digit of a frame completes its dwell
- load_ack  out  1  1-cycle pulse when a shadow value is committed to the display

## Operation
- State:
  - prescaler pcnt, 0..PRESCALE-1
  - digit index idx, width max(1,$clog2(DIGITS))
  - shadow register and pending flag
  - active display register
- Load:
  - load=1 writes data to the shadow register and sets pending.
  - A later load before commit overwrites the shadow; the newest value wins.
- Commit:
  - Occurs at the frame boundary: enable=1, pcnt=PRESCALE-1, idx=DIGITS-1.
  - If pending, active <= shadow, pending cleared, load_ack pulses.
  - If load coincides with the boundary, the incoming data is committed directly and pending stays 0.
- Disabled:
  - Loads commit immediately on the next edge (load_ack pulses).
  - pcnt and idx are forced to 0.
- Scan:
  - pcnt increments each enabled cycle.
  - At PRESCALE-1, pcnt wraps to 0 and idx advances, wrapping from DIGITS-1 to 0.
- Decode: standard hex font.
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, B=1F, C=4E, D=3D, E=4F, F=47
- Outputs:
  - When enabled: seg <= font(active nibble idx), digit_sel <= onehot(idx).
  - When disabled: seg <= 0, digit_sel <= 0.

## Timing
- All outputs are registered. Reset values: seg=0, digit_sel=0, frame_done=0, load_ack=0.
- Reset also clears pcnt, idx, shadow, pending and active.
- Output latency: one cycle from idx/active to seg/digit_sel.
- Digit dwell: exactly PRESCALE cycles. Frame length: DIGITS*PRESCALE cycles.
- frame_done and load_ack assert on the edge after the boundary cycle, in the same cycle.
- The committed value first appears on seg (digit 0) in the same cycle as load_ack.
- Enable deassert: seg and digit_sel are 0 from the next cycle.
- Enable reassert: digit 0 is driven on the next cycle with a full PRESCALE dwell.
- Reset mid-frame: everything returns to reset values immediately; any pending load is discarded.

## Configuration
- SEG7_SCAN_LZB_EN defined: leading-zero blanking.
  - Digit i (i>0) drives seg=0 when it and all higher active nibbles are 0.
  - digit_sel still asserts for that digit.
  - Digit 0 is never blanked.
- Undefined: all digits are always decoded.

## Structure
- Package seg7_pkg holds:
  - the 16-entry font constant array SEG7_FONT
  - SEG7_BLANK = 7'h00
  - segment bit-index constants
- Sub-module hex_to_seg7 (combinational nibble-to-segment decoder), instantiated once on the muxed nibble.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4.
- Reset asserted mid-scan -> seg=0, digit_sel=0, frame_done=0, load_ack=0 immediately, with no pending commit after release.
- enable=1, load 16'h12AF, wait for boundary -> load_ack, then:
  - digit_sel=0001, seg=47 for 4 cycles
  - 0010/77, then 0100/6D, then 1000/30
  - frame_done every 16 cycles
- Load 16'h1111 then 16'h2222 within one frame -> single load_ack; all digits show 6D.
- Load 16'h3333 exactly at the boundary cycle -> committed at that boundary; load_ack on the next edge.
- Drop enable for 5 cycles mid-digit-2 -> seg=0 and digit_sel=0 from the next cycle; re-enable restarts at digit 0 with a 4-cycle dwell.
- With SEG7_SCAN_LZB_EN, data 16'h0050 -> digits 3,2 seg=0; digit 1 = 5B; digit 0 = 7E. Data 16'h0000 -> digit 0 = 7E.
